// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with configurable width and depth
// (any depth >= 2). It offers a standard or first-word-fall-through read port,
// a fill-level output with almost-full/almost-empty flags, sticky
// overflow/underflow flags, and a synchronous flush.
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter bit FWFT      = 1'b0,
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic              underflow
);

    // Pointer width covers indices 0..DEPTH-1. Pointers wrap explicitly at
    // DEPTH-1, so non-power-of-two depths never index past the array.
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] AE_LVL   = LVL_W'(AE_THRESH);

    // Storage and registered state
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;
    logic              r_underflow;

    // Combinational decodes and next-state values
    logic              w_full;
    logic              w_empty;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_wr_fire;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [DATA_W-1:0] w_head;

    // Status flags are pure decodes of the registered level, so an access
    // shows up in them one cycle after it is accepted.
    assign w_full       = (r_level == FULL_LVL);
    assign w_empty      = (r_level == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= AF_LVL);
    assign almost_empty = (r_level <= AE_LVL);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A read is accepted whenever data is present. A write is accepted when
    // there is room, or when a read frees a slot in the same cycle.
    assign w_rd_acc  = rd_en & ~w_empty;
    assign w_wr_acc  = wr_en & (~w_full | w_rd_acc);
    // A flush cycle ignores write requests, so memory is not touched then.
    assign w_wr_fire = w_wr_acc & ~clear;

    assign w_head = r_mem[r_rd_ptr];

    // Next pointer and level values for accepted accesses
    always_comb begin
        // NOTE: every always_comb output gets a default first, so that no path leaves it unassigned and infers a latch.
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage array: reset zeroes it, and accepted writes land at wr_ptr
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) assignments, so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: the memory is reset here deliberately, because reset must leave every entry at zero; flush does not clear it.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and sticky error flags: reset first, then flush, then normal operation
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            if (wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // The head word is shown combinationally while the FIFO holds data.
            // rd_en pops it, and the next word appears once rd_ptr has moved.
            assign rd_data  = w_empty ? '0 : w_head;
            assign rd_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_W-1:0] r_rd_data;
            logic              r_rd_valid;

            // Registered read: the popped word and a one-cycle valid pulse follow rd_en by a cycle
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (clear) begin
                    // rd_data keeps its last value across a flush
                    r_rd_valid <= 1'b0;
                end else if (w_rd_acc) begin
                    r_rd_data  <= w_head;
                    r_rd_valid <= 1'b1;
                end else begin
                    r_rd_valid <= 1'b0;
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param. One standard-mode instance and one FWFT instance
// share the same stimulus. Both are checked against a queue-based model of the
// FIFO behaviour.
module tb_sync_fifo_param;

    localparam int DW  = 32;
    localparam int DEP = 5;
    localparam int LW  = $clog2(DEP + 1);
    localparam int VW  = LW + 7 + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    // Standard-mode instance outputs
    logic [DW-1:0] s_rd_data;
    logic          s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [LW-1:0] s_level;
    // FWFT instance outputs
    logic [DW-1:0] f_rd_data;
    logic          f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [LW-1:0] f_level;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [DW-1:0] q [$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_valid = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b0)) u_std (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .level(s_level), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .level(f_level), .overflow(f_ovf), .underflow(f_unf)
    );

    // Model of one clock edge: a queue of stored words plus the error flags
    function automatic void model_step(input logic rst, input logic clr, input logic we,
                                       input logic [DW-1:0] wd, input logic re);
        bit racc;
        bit wacc;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_rd_data = '0; m_rd_valid = 1'b0;
        end else if (clr) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_rd_valid = 1'b0;
        end else begin
            racc = re && (q.size() > 0);
            wacc = we && ((q.size() < DEP) || racc);
            if (we && !wacc) m_ovf = 1'b1;
            if (re && !racc) m_unf = 1'b1;
            if (racc) begin
                m_rd_data  = q.pop_front();
                m_rd_valid = 1'b1;
            end else begin
                m_rd_valid = 1'b0;
            end
            if (wacc) q.push_back(wd);
        end
    endfunction

    // Expected output bundle {level, full, empty, af, ae, ovf, unf, valid, data}
    function automatic logic [VW-1:0] exp_vec(input bit fwft);
        int            lvl = q.size();
        logic          v;
        logic [DW-1:0] d;
        if (fwft) begin
            v = (lvl != 0);
            d = v ? q[0] : '0;
        end else begin
            v = m_rd_valid;
            d = m_rd_data;
        end
        return {LW'(lvl), lvl == DEP, lvl == 0, lvl >= 4, lvl <= 1, m_ovf, m_unf, v, d};
    endfunction

    function automatic logic [VW-1:0] got_std();
        return {s_level, s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_rd_valid, s_rd_data};
    endfunction

    function automatic logic [VW-1:0] got_fwft();
        return {f_level, f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_rd_valid, f_rd_data};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, then settle 1 ns past it
    task automatic step(input logic rst, input logic clr, input logic we,
                        input logic [DW-1:0] wd, input logic re);
        reset = rst; clear = clr; wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk);
        model_step(rst, clr, we, wd, re);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, '0, 0);
        step(1, 0, 1, 32'hFFFF_FFFF, 1);
        n_cmp++;
        if (got_std() !== exp_vec(1'b0)) begin
            n_mis++; $display("FAIL reset std: got %h exp %h", got_std(), exp_vec(1'b0));
        end
        n_cmp++;
        if (got_fwft() !== exp_vec(1'b1)) begin
            n_mis++; $display("FAIL reset fwft: got %h exp %h", got_fwft(), exp_vec(1'b1));
        end
        n_cmp++;
        if ({s_level, s_empty, s_full, s_rd_valid} !== {LW'(0), 1'b1, 1'b0, 1'b0}) begin
            n_mis++; $display("FAIL reset_flags: got lvl=%0d e=%b f=%b v=%b exp 0/1/0/0", s_level, s_empty, s_full, s_rd_valid);
        end
        step(0, 0, 0, '0, 0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEP; i++) begin
            step(0, 0, 1, 32'(32'hA0 + i), 0);
            n_cmp++;
            if (got_std() !== exp_vec(1'b0)) begin
                n_mis++; $display("FAIL fill[%0d] std: got %h exp %h", i, got_std(), exp_vec(1'b0));
            end
            n_cmp++;
            if (got_fwft() !== exp_vec(1'b1)) begin
                n_mis++; $display("FAIL fill[%0d] fwft: got %h exp %h", i, got_fwft(), exp_vec(1'b1));
            end
            n_cmp++;
            if (s_level !== LW'(i + 1)) begin
                n_mis++; $display("FAIL fill_level[%0d]: got %0d exp %0d", i, s_level, i + 1);
            end
        end
        step(0, 0, 1, 32'hA5, 0);
        n_cmp++;
        if ({s_ovf, s_level, s_full, f_ovf} !== {1'b1, LW'(DEP), 1'b1, 1'b1}) begin
            n_mis++; $display("FAIL fill_overflow: got ovf=%b lvl=%0d full=%b fovf=%b exp 1/5/1/1", s_ovf, s_level, s_full, f_ovf);
        end
    endtask

    task automatic test_drain_std();
        for (int i = 0; i < DEP; i++) begin
            step(0, 0, 0, '0, 1);
            n_cmp++;
            if ({s_rd_valid, s_rd_data} !== {1'b1, 32'(32'hA0 + i)}) begin
                n_mis++; $display("FAIL drain[%0d]: got v=%b d=%h exp v=1 d=%h", i, s_rd_valid, s_rd_data, 32'hA0 + i);
            end
            n_cmp++;
            if (got_fwft() !== exp_vec(1'b1)) begin
                n_mis++; $display("FAIL drain[%0d] fwft: got %h exp %h", i, got_fwft(), exp_vec(1'b1));
            end
        end
        step(0, 0, 0, '0, 0);
        n_cmp++;
        if ({s_rd_valid, s_empty} !== 2'b01) begin
            n_mis++; $display("FAIL drain_pulse: got v=%b e=%b exp v=0 e=1", s_rd_valid, s_empty);
        end
        step(0, 0, 0, '0, 1);
        n_cmp++;
        if ({s_unf, s_rd_valid, s_rd_data} !== {1'b1, 1'b0, 32'hA4}) begin
            n_mis++; $display("FAIL underflow: got unf=%b v=%b d=%h exp 1/0/a4", s_unf, s_rd_valid, s_rd_data);
        end
        n_cmp++;
        if (got_std() !== exp_vec(1'b0)) begin
            n_mis++; $display("FAIL underflow std: got %h exp %h", got_std(), exp_vec(1'b0));
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'(32'hE0 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
        for (int i = 0; i < DEP; i++) begin
            step(0, 0, 1, 32'(32'hB0 + i), 0);
            n_cmp++;
            if (got_fwft() !== exp_vec(1'b1)) begin
                n_mis++; $display("FAIL wrap_wr[%0d] fwft: got %h exp %h", i, got_fwft(), exp_vec(1'b1));
            end
        end
        for (int i = 0; i < DEP; i++) begin
            step(0, 0, 0, '0, 1);
            n_cmp++;
            if ({s_rd_valid, s_rd_data} !== {1'b1, 32'(32'hB0 + i)}) begin
                n_mis++; $display("FAIL wrap_rd[%0d]: got v=%b d=%h exp v=1 d=%h", i, s_rd_valid, s_rd_data, 32'hB0 + i);
            end
            n_cmp++;
            if (got_fwft() !== exp_vec(1'b1)) begin
                n_mis++; $display("FAIL wrap_rd[%0d] fwft: got %h exp %h", i, got_fwft(), exp_vec(1'b1));
            end
        end
        n_cmp++;
        if ({s_ovf, s_unf, f_ovf, f_unf, s_empty} !== 5'b00001) begin
            n_mis++; $display("FAIL wrap_flags: got %b exp 00001", {s_ovf, s_unf, f_ovf, f_unf, s_empty});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEP; i++) step(0, 0, 1, 32'(32'hC0 + i), 0);
        step(0, 0, 1, 32'hC5, 1);
        n_cmp++;
        if ({s_rd_valid, s_rd_data, s_level, s_ovf} !== {1'b1, 32'hC0, LW'(DEP), 1'b0}) begin
            n_mis++; $display("FAIL full_rw std: got v=%b d=%h lvl=%0d ovf=%b exp 1/c0/5/0", s_rd_valid, s_rd_data, s_level, s_ovf);
        end
        n_cmp++;
        if ({f_rd_data, f_level, f_ovf} !== {32'hC1, LW'(DEP), 1'b0}) begin
            n_mis++; $display("FAIL full_rw fwft: got d=%h lvl=%0d ovf=%b exp c1/5/0", f_rd_data, f_level, f_ovf);
        end
        for (int i = 0; i < DEP; i++) begin
            step(0, 0, 0, '0, 1);
            n_cmp++;
            if (got_std() !== exp_vec(1'b0)) begin
                n_mis++; $display("FAIL full_rw_drain[%0d] std: got %h exp %h", i, got_std(), exp_vec(1'b0));
            end
        end
        n_cmp++;
        if (s_rd_data !== 32'hC5) begin
            n_mis++; $display("FAIL full_rw_last: got %h exp c5", s_rd_data);
        end
    endtask

    task automatic test_fwft();
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, 32'hD0, 0);
        n_cmp++;
        if ({f_rd_valid, f_rd_data} !== {1'b1, 32'hD0}) begin
            n_mis++; $display("FAIL fwft_show: got v=%b d=%h exp v=1 d=d0", f_rd_valid, f_rd_data);
        end
        step(0, 0, 0, '0, 1);
        n_cmp++;
        if ({f_empty, f_rd_valid, f_rd_data} !== {1'b1, 1'b0, 32'h0}) begin
            n_mis++; $display("FAIL fwft_pop: got e=%b v=%b d=%h exp 1/0/0", f_empty, f_rd_valid, f_rd_data);
        end
    endtask

    task automatic test_clear();
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < DEP + 1; i++) step(0, 0, 1, 32'(32'h50 + i), 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        n_cmp++;
        if ({s_level, s_ovf} !== {LW'(3), 1'b1}) begin
            n_mis++; $display("FAIL clear_pre: got lvl=%0d ovf=%b exp 3/1", s_level, s_ovf);
        end
        step(0, 1, 1, 32'hEE, 0);
        n_cmp++;
        if ({s_level, s_empty, s_ovf, f_level, f_empty, f_ovf} !== {LW'(0), 1'b1, 1'b0, LW'(0), 1'b1, 1'b0}) begin
            n_mis++; $display("FAIL clear: got s=%0d/%b/%b f=%0d/%b/%b exp 0/1/0", s_level, s_empty, s_ovf, f_level, f_empty, f_ovf);
        end
        n_cmp++;
        if (got_std() !== exp_vec(1'b0)) begin
            n_mis++; $display("FAIL clear std: got %h exp %h", got_std(), exp_vec(1'b0));
        end
        step(0, 0, 0, '0, 0);
        n_cmp++;
        if ({f_rd_valid, f_level} !== {1'b0, LW'(0)}) begin
            n_mis++; $display("FAIL clear_ignored_write: got v=%b lvl=%0d exp 0/0", f_rd_valid, f_level);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'(32'h70 + i), 0);
        step(0, 0, 1, 32'h73, 1);
        step(1, 0, 1, 32'h74, 1);
        n_cmp++;
        if (got_std() !== {LW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_mis++; $display("FAIL reset_mid std: got %h", got_std());
        end
        n_cmp++;
        if (got_fwft() !== {LW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_mis++; $display("FAIL reset_mid fwft: got %h", got_fwft());
        end
    endtask

    task automatic test_random();
        logic rc;
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 600; i++) begin
            rc = ($urandom_range(0, 59) == 0);
            step(0, rc, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0);
            n_cmp++;
            if (got_std() !== exp_vec(1'b0)) begin
                n_mis++; $display("FAIL random[%0d] std: got %h exp %h", i, got_std(), exp_vec(1'b0));
            end
            n_cmp++;
            if (got_fwft() !== exp_vec(1'b1)) begin
                n_mis++; $display("FAIL random[%0d] fwft: got %h exp %h", i, got_fwft(), exp_vec(1'b1));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain_std();
        test_wrap();
        test_back_to_back();
        test_fwft();
        test_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO. Successor to the fixed 32-bit, 5-entry user-area FIFO.
- Adds:
  - configurable width and depth, including non-power-of-two depths;
  - standard or first-word-fall-through (FWFT) read mode;
  - fill-level output and almost-full/almost-empty flags;
  - write-on-full when a read is accepted in the same cycle;
  - sticky overflow/underflow error flags;
  - synchronous flush.
- Buffers data between a WB/LA-side producer and a user-logic consumer (e.g. FIR data path).

Parameters:
- DATA_W, 32, data word width in bits (>=1)
- DEPTH, 8, number of storage entries (>=2; need not be a power of two)
- AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- LVL_W, $clog2(DEPTH+1), width of the level output (derived, not overridden)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush: empties the FIFO, clears the error flags
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read/pop request
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data holds valid popped/head data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  LVL_W  current number of stored entries
- overflow  out  1  sticky: a write request was rejected
- underflow  out  1  sticky: a read request was rejected

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset, evaluated at the clk edge with highest priority, gives:
  - wr_ptr = rd_ptr = level = 0; all memory entries = 0;
  - rd_data = 0, rd_valid = 0, overflow = underflow = 0;
  - flags follow as empty = 1, full = 0.
  - Reset mid-operation discards all contents and in-flight reads.
- clear, second priority:
  - same as reset except memory contents are not zeroed and, in standard mode, rd_data holds its value;
  - wr_en and rd_en are ignored in a clear cycle.
- Acceptance, combinational:
  - rd_acc = rd_en & ~empty
  - wr_acc = wr_en & (~full | rd_acc)
  - When full, a write is accepted only if a read is accepted the same cycle.
  - When empty, a simultaneous write is accepted and the read is rejected.
- Write: on wr_acc, mem[wr_ptr] <= wr_data; wr_ptr advances, wrapping from DEPTH-1 to 0.
- Read pointer: on rd_acc, rd_ptr advances with the same wrap rule.
- Level: level <= level + wr_acc - rd_acc. Never exceeds DEPTH, never goes below 0.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered level. They reflect an access in the cycle after it.
- Standard mode (FWFT=0):
  - on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 (one-cycle latency);
  - otherwise rd_valid <= 0 and rd_data holds.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] when ~empty, else 0; rd_valid = ~empty (both combinational from registered state);
  - rd_en pops the displayed word, and the next word appears the cycle after;
  - a word written into an empty FIFO appears on rd_data the cycle after the write.
- Error flags:
  - overflow <= 1 on wr_en & ~wr_acc;
  - underflow <= 1 on rd_en & ~rd_acc;
  - both hold until reset or clear. A rejected access changes no other state.
- Simultaneous wr_acc & rd_acc at any level: level unchanged, both pointers advance.

Test Plan (DATA_W=32, DEPTH=5, AF_THRESH=4, AE_THRESH=1 unless stated):
- Reset, then write 0xA0..0xA4 on 5 consecutive cycles:
  - level steps 1..5; almost_empty drops when level reaches 2; almost_full rises at level 4; full = 1 at level 5;
  - a 6th write sets overflow = 1 and level stays 5.
- FWFT=0, from full: read 5 times:
  - rd_data = 0xA0..0xA4, each with a 1-cycle rd_valid pulse one cycle after rd_en;
  - then empty = 1; a further rd_en sets underflow = 1 and rd_data holds 0xA4.
- Wrap: write 3, read 3, write 5 (0xB0..0xB4), read 5:
  - data returns in order 0xB0..0xB4 across the pointer wrap 4->0;
  - no error flags.
- Full with simultaneous wr_en+rd_en (wr_data 0xC5):
  - read returns the oldest word; the write is accepted; level stays 5; overflow stays 0.
- FWFT=1: write 0xD0 into an empty FIFO:
  - next cycle rd_valid = 1, rd_data = 0xD0;
  - a rd_en that cycle gives empty = 1, rd_valid = 0, rd_data = 0 on the following cycle.
- With 3 entries and overflow = 1, assert clear together with wr_en:
  - next cycle level = 0, empty = 1, overflow = 0, write ignored.
  - Repeat with reset asserted mid-burst: all outputs return to their reset values.
